// File: rtl/fifo_arb_pkg.sv
// Shared sizing and arithmetic helpers for the FIFO push arbiter.
// All functions are constant-foldable so they can size parameters.
package fifo_arb_pkg;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Burst counter must hold 0..burst_max inclusive.
  function automatic int burst_width(input int burst_max);
    return (burst_max > 0) ? $clog2(burst_max + 1) : 1;
  endfunction

  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] max_v;
    max_v = (64'd1 << w) - 64'd1;
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority picker: the first set bit of req at or
// after index base (wrapping) wins.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = id_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] base,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] id,
  output logic           found
);

  always_comb begin
    int idx;
    idx    = 0;
    onehot = '0;
    id     = '0;
    found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(base) + k) % N;
      if (!found && req[idx]) begin
        found       = 1'b1;
        onehot[idx] = 1'b1;
        id          = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter with burst lock sharing one FIFO write port among
// N_REQ producers; zero-latency grant and saturating per-requester counters.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          en_mask,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_push,
  output logic [DATA_W-1:0]         fifo_data,
  output logic [id_width(N_REQ)-1:0] grant_id,
  input  logic                      clear_stats,
  output logic [N_REQ*CNT_W-1:0]    grant_cnt
);

  localparam int IDW = id_width(N_REQ);
  localparam int BW  = burst_width(BURST_MAX);

  logic [IDW-1:0]   last_id_q, last_id_d;
  logic [BW-1:0]    burst_cnt_q, burst_cnt_d;
  logic             lock_q, lock_d;
  logic [CNT_W-1:0] grant_cnt_q [N_REQ];
  logic [CNT_W-1:0] grant_cnt_d [N_REQ];

  logic [N_REQ-1:0] eligible;
  logic [IDW-1:0]   base_id;
  logic [N_REQ-1:0] rr_onehot;
  logic [IDW-1:0]   rr_id;
  logic             rr_found;
  logic             lock_hit;
  logic             grant;
  logic [IDW-1:0]   gid;

  assign eligible = req_valid & en_mask;
  assign base_id  = (last_id_q == IDW'(N_REQ - 1)) ? '0 : last_id_q + IDW'(1);

  rr_arbiter #(.N(N_REQ), .IDW(IDW)) u_rr (
    .req    (eligible),
    .base   (base_id),
    .onehot (rr_onehot),
    .id     (rr_id),
    .found  (rr_found)
  );

  // The owner keeps the port only while it stays eligible and has burst budget left.
  assign lock_hit = lock_q && eligible[last_id_q] && (burst_cnt_q < BW'(BURST_MAX));
  assign grant    = !rst && !fifo_full && rr_found;
  assign gid      = lock_hit ? last_id_q : rr_id;

  always_comb begin
    req_ready = '0;
    fifo_push = 1'b0;
    fifo_data = '0;
    grant_id  = '0;
    if (grant) begin
      req_ready = lock_hit ? (N_REQ'(1) << last_id_q) : rr_onehot;
      fifo_push = 1'b1;
      grant_id  = gid;
      for (int i = 0; i < N_REQ; i++) begin
        if (gid == IDW'(i)) fifo_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    last_id_d   = last_id_q;
    burst_cnt_d = burst_cnt_q;
    lock_d      = lock_q;
    if (grant) begin
      if (lock_hit) begin
        burst_cnt_d = burst_cnt_q + BW'(1);
      end else begin
        last_id_d   = rr_id;
        burst_cnt_d = BW'(1);
        lock_d      = 1'b1;
      end
    end else if (!fifo_full) begin
      lock_d      = 1'b0;
      burst_cnt_d = '0;
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      grant_cnt_d[i] = grant_cnt_q[i];
      if (clear_stats) begin
        grant_cnt_d[i] = '0;
      end else if (grant && gid == IDW'(i)) begin
        grant_cnt_d[i] = CNT_W'(sat_inc(64'(grant_cnt_q[i]), CNT_W));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_id_q   <= IDW'(N_REQ - 1);
      burst_cnt_q <= '0;
      lock_q      <= 1'b0;
      for (int i = 0; i < N_REQ; i++) grant_cnt_q[i] <= '0;
    end else begin
      last_id_q   <= last_id_d;
      burst_cnt_q <= burst_cnt_d;
      lock_q      <= lock_d;
      for (int i = 0; i < N_REQ; i++) grant_cnt_q[i] <= grant_cnt_d[i];
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt_out
    assign grant_cnt[g*CNT_W +: CNT_W] = grant_cnt_q[g];
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench: three arbiter configurations share one stimulus bus;
// expected pushes go into a scoreboard queue and are popped each cycle.
module tb_fifo_push_arbiter;

  typedef struct packed {
    logic       p;
    logic [1:0] id;
    logic [7:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  en_mask;
  logic [31:0] req_data;
  logic        fifo_full;
  logic        clear_stats;

  logic [3:0]  ready_w [3];
  logic        push_w  [3];
  logic [7:0]  data_w  [3];
  logic [1:0]  id_w    [3];
  logic [63:0] cnt0, cnt1;
  logic [15:0] cnt2;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic [7:0] rd [4];

  always #5 clk = ~clk;

  // dut 0: pure round-robin, dut 1: burst of 4, dut 2: burst of 4 with 4-bit counters
  fifo_push_arbiter #(.N_REQ(4), .DATA_W(8), .BURST_MAX(1), .CNT_W(16)) dut_rr (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .en_mask(en_mask),
    .req_ready(ready_w[0]), .fifo_full(fifo_full), .fifo_push(push_w[0]), .fifo_data(data_w[0]),
    .grant_id(id_w[0]), .clear_stats(clear_stats), .grant_cnt(cnt0));

  fifo_push_arbiter #(.N_REQ(4), .DATA_W(8), .BURST_MAX(4), .CNT_W(16)) dut_burst (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .en_mask(en_mask),
    .req_ready(ready_w[1]), .fifo_full(fifo_full), .fifo_push(push_w[1]), .fifo_data(data_w[1]),
    .grant_id(id_w[1]), .clear_stats(clear_stats), .grant_cnt(cnt1));

  fifo_push_arbiter #(.N_REQ(4), .DATA_W(8), .BURST_MAX(4), .CNT_W(4)) dut_cnt (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .en_mask(en_mask),
    .req_ready(ready_w[2]), .fifo_full(fifo_full), .fifo_push(push_w[2]), .fifo_data(data_w[2]),
    .grant_id(id_w[2]), .clear_stats(clear_stats), .grant_cnt(cnt2));

  task automatic drive(input logic [3:0] v, input logic [3:0] m, input logic f, input logic c);
    req_valid   = v;
    en_mask     = m;
    fifo_full   = f;
    clear_stats = c;
    for (int i = 0; i < 4; i++) begin
      rd[i] = 8'($urandom);
      req_data[i*8 +: 8] = rd[i];
    end
  endtask

  function automatic exp_t mk(input logic p, input int id);
    exp_t e;
    e.p  = p;
    e.id = p ? 2'(id) : 2'b0;
    e.d  = p ? rd[id] : 8'h00;
    return e;
  endfunction

  // grant_id is only meaningful while pushing
  function automatic logic [14:0] obs(input int d);
    return {push_w[d], ready_w[d], push_w[d] ? id_w[d] : 2'b00, data_w[d]};
  endfunction

  function automatic logic [14:0] expv(input exp_t e);
    return {e.p, e.p ? 4'(4'b0001 << e.id) : 4'b0000, e.id, e.d};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    drive(4'h0, 4'hF, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(4'hF, 4'hF, 1'b0, 1'b0);
      sb.push_back(mk(1'b0, 0));
      @(negedge clk);
      e = sb.pop_front();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs(d) !== expv(e)) begin
          errors++;
          $display("FAIL reset_outputs dut%0d cyc%0d: got %h want %h", d, k, obs(d), expv(e));
        end
      end
      if (k == 1) begin
        checks++;
        if (cnt1 !== 64'h0 || cnt2 !== 16'h0) begin
          errors++;
          $display("FAIL reset_counters: got %h/%h want 0", cnt1, cnt2);
        end
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    drive(4'hF, 4'hF, 1'b0, 1'b0);
    sb.push_back(mk(1'b1, 0));
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (obs(1) !== expv(e)) begin
      errors++;
      $display("FAIL reset_first_grant: got %h want %h", obs(1), expv(e));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    exp_t e;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(4'hF, 4'hF, 1'b0, 1'b0);
      sb.push_back(mk(1'b1, k % 4));
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs(0) !== expv(e)) begin
        errors++;
        $display("FAIL round_robin cyc%0d: got %h want %h", k, obs(0), expv(e));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_burst();
    exp_t e;
    int seq [10] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1};
    do_reset();
    for (int k = 0; k < 16; k++) begin
      if (k < 10) begin
        drive(4'b0110, 4'hF, 1'b0, 1'b0);
        sb.push_back(mk(1'b1, seq[k]));
      end else begin
        drive(4'b0100, 4'hF, 1'b0, 1'b0);
        sb.push_back(mk(1'b1, 2));
      end
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs(1) !== expv(e)) begin
        errors++;
        $display("FAIL burst cyc%0d: got %h want %h", k, obs(1), expv(e));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_full_stall();
    exp_t e;
    int seq [8] = '{1, 1, -1, -1, -1, 1, 1, 2};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(4'b0110, 4'hF, (k >= 2 && k <= 4), 1'b0);
      sb.push_back(mk(seq[k] >= 0, (seq[k] >= 0) ? seq[k] : 0));
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs(1) !== expv(e)) begin
        errors++;
        $display("FAIL full_stall cyc%0d: got %h want %h", k, obs(1), expv(e));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_en_mask();
    exp_t e;
    int seq [13] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};
    do_reset();
    for (int k = 0; k < 13; k++) begin
      drive(4'hF, (k < 9) ? 4'b1110 : 4'b1111, 1'b0, 1'b0);
      sb.push_back(mk(1'b1, seq[k]));
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs(1) !== expv(e)) begin
        errors++;
        $display("FAIL en_mask cyc%0d: got %h want %h", k, obs(1), expv(e));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_counters();
    exp_t e;
    do_reset();
    for (int n = 0; n < 20; n++) begin
      drive(4'b1000, 4'hF, 1'b0, 1'b0);
      sb.push_back(mk(1'b1, 3));
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs(2) !== expv(e)) begin
        errors++;
        $display("FAIL cnt_grant cyc%0d: got %h want %h", n, obs(2), expv(e));
      end
      checks++;
      if (cnt2 !== {4'((n < 15) ? n : 15), 12'h000}) begin
        errors++;
        $display("FAIL cnt_value cyc%0d: got %h want %h", n, cnt2, {4'((n < 15) ? n : 15), 12'h000});
      end
      @(posedge clk); #1;
    end
    drive(4'b1000, 4'hF, 1'b0, 1'b1);
    sb.push_back(mk(1'b1, 3));
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (obs(2) !== expv(e)) begin
      errors++;
      $display("FAIL cnt_clear_grant: got %h want %h", obs(2), expv(e));
    end
    checks++;
    if (cnt2 !== 16'hF000) begin
      errors++;
      $display("FAIL cnt_saturated: got %h want f000", cnt2);
    end
    @(posedge clk); #1;
    drive(4'b0000, 4'hF, 1'b0, 1'b0);
    sb.push_back(mk(1'b0, 0));
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (obs(2) !== expv(e)) begin
      errors++;
      $display("FAIL cnt_idle: got %h want %h", obs(2), expv(e));
    end
    checks++;
    if (cnt2 !== 16'h0000) begin
      errors++;
      $display("FAIL cnt_cleared: got %h want 0000", cnt2);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst         = 1'b1;
    req_valid   = '0;
    en_mask     = '1;
    req_data    = '0;
    fifo_full   = 1'b0;
    clear_stats = 1'b0;
    test_reset();
    test_round_robin();
    test_burst();
    test_full_stall();
    test_en_mask();
    test_counters();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
